diff_apply: RTL and testbench
=============================

// Module: diff_apply
// PURPOSE
//  Inverse of the lowest-differing-bit finder. Takes a base word and a bit position
//    (the index of the lowest bit where two words differ) and rebuilds the partner
//    word: base with that bit flipped.
//  Iterative unit: walks a one-hot mask up from bit 0 to the target position.
//  Valid/ready handshake on both sides. Sits on the datapath next to the finder,
//    feeding writeback/compare logic.
// PARAMETERS
//  WIDTH   32               data word width in bits
//  POS_W   $clog2(WIDTH)=5  width of the position field
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  in_valid   in   1      request valid
//  in_ready   out  1      unit can accept a request (high only in IDLE)
//  base       in   WIDTH  base word
//  pos        in   POS_W  bit index to flip
//  no_diff    in   1      words equal: return base unchanged, no scan
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  base ^ (1<<pos), or base if no_diff/err
//  err        out  1      pos >= WIDTH (only possible if WIDTH is not a power of 2)
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; out_valid=0, result=0, err=0;
//    internal mask=0, cnt=0. Reset mid-scan aborts the op; nothing is emitted.
//  in_ready = (state==IDLE). Combinational from state only, never from in_valid.
//  FSM IDLE -> SCAN -> DONE -> IDLE:
//   IDLE: on in_valid&&in_ready, capture base, pos, no_diff; set mask=1, cnt=0.
//     If no_diff or pos>=WIDTH, go to DONE directly:
//       result=base; err=(pos>=WIDTH && !no_diff).
//     Otherwise go to SCAN.
//   SCAN: each cycle, if cnt==pos_r:
//       result=base_r^mask; err=0; go to DONE.
//     Else: mask<=mask<<1; cnt<=cnt+1.
//   DONE: out_valid=1; result/err held stable.
//     On out_ready, go to IDLE and clear out_valid on the same edge.
//  Latency, counted from the accept edge T0:
//   - out_valid high after edge T0+pos+1;
//   - no_diff/err case: high after edge T0+1.
//  Throughput: one op in flight. A new request is accepted no earlier than the
//    cycle after the output handshake (no same-cycle accept+emit).
//  Boundaries:
//   - pos=0: one SCAN cycle;
//   - pos=WIDTH-1: mask reaches the MSB and never wraps; cnt never exceeds pos.
//  in_valid while busy: ignored (in_ready=0); the source must hold its request.
//  out_ready asserted while out_valid=0: no effect.
//  Inputs are sampled only at the accept edge; later changes have no effect.
// STRUCTURE
//  Shared include diff_defs.vh:
//   - WIDTH/POS_W defaults;
//   - state encodings S_IDLE=2'd0, S_SCAN=2'd1, S_DONE=2'd2;
//   - also used by the finder and its bench.
//  Single module. No sub-module: the mask shifter and counter are a few lines.
//  Unused state encoding 2'd3 recovers to IDLE.
// TESTING
//  1 reset: rst_n=0 mid-SCAN (base=32'hFFFF0000, pos=20)
//      -> out_valid=0, result=0, in_ready=1 immediately; no output after release.
//  2 base=32'h0000_0000, pos=0
//      -> result=32'h0000_0001, out_valid after T0+1, err=0.
//  3 base=32'hFFFF_FFFF, pos=31
//      -> result=32'h7FFF_FFFF, out_valid after T0+32; in_ready=0 throughout.
//  4 no_diff=1, base=32'hDEAD_BEEF, pos=7
//      -> result=32'hDEAD_BEEF after T0+1, err=0.
//  5 backpressure: pos=4, base=0, out_ready=0 for 10 cycles
//      -> result=32'h10 held with out_valid high;
//      -> second request held on in_valid is accepted only after the out_ready handshake.
//  6 round-trip vs finder: 1000 random a,b with a!=b; pos=diff(a,b)
//      -> result matches a ^ (1<<pos); the finder on (a,result) returns pos again.

Source files
------------

// File: rtl/diff_apply_pkg.sv
// Shared definitions for the diff_apply block and its neighbours on the
// datapath: default word geometry and the FSM state encodings.
package diff_apply_pkg;

   // Default data word width and width of the bit-position field.
   localparam int DIFF_WIDTH = 32;
   localparam int DIFF_POS_W = $clog2(DIFF_WIDTH);

   // FSM encodings; the spare code 2'd3 is never entered on purpose and
   // recovers to S_IDLE.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } diff_state_e;

endpackage : diff_apply_pkg

// File: rtl/diff_apply.sv
// diff_apply: rebuilds the partner word of a lowest-differing-bit pair.
// Given a base word and a bit index, returns base with that bit flipped.
// The flip bit is located by walking a one-hot mask up from bit 0, one
// position per cycle, so an op at index pos takes pos+1 cycles to finish.
// One op in flight; valid/ready handshake on both sides.
module diff_apply
   import diff_apply_pkg::*;
#(
   parameter int WIDTH = DIFF_WIDTH,
   parameter int POS_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] base,
   input  logic [POS_W-1:0] pos,
   input  logic             no_diff,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   // WIDTH expressed one bit wider than pos, so the range test below is a
   // genuine comparison even when WIDTH is a power of two.
   localparam logic [POS_W:0] WIDTH_EXT = (POS_W + 1)'(WIDTH);

   diff_state_e      state;
   logic [WIDTH-1:0] base_r;
   logic [POS_W-1:0] pos_r;
   logic [WIDTH-1:0] mask;
   logic [POS_W-1:0] cnt;
   logic             pos_oob;

   // Ready depends on state alone, so a source may hold in_valid without
   // creating a combinational loop through this unit.
   assign in_ready = (state == S_IDLE);

   // Out-of-range index; can only be true when WIDTH is not a power of two.
   assign pos_oob = ({1'b0, pos} >= WIDTH_EXT);

   // Control FSM, mask walker, counter and registered outputs.
   // NOTE: every register here, including the captured operands, is reset;
   // the block is small and a known state after reset eases debug.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         base_r    <= '0;
         pos_r     <= '0;
         mask      <= '0;
         cnt       <= '0;
         result    <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // reads the values held before this edge.
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  base_r <= base;
                  pos_r  <= pos;
                  mask   <= WIDTH'(1);
                  cnt    <= '0;
                  if (no_diff || pos_oob) begin
                     // Nothing to flip: result is the base itself. out_valid
                     // is raised one cycle later from DONE, matching the
                     // pos=0 latency so every op takes at least one cycle.
                     result <= base;
                     err    <= pos_oob && !no_diff;
                     state  <= S_DONE;
                  end else begin
                     state <= S_SCAN;
                  end
               end
            end

            S_SCAN: begin
               if (cnt == pos_r) begin
                  // Mask now sits on the target bit; flip and present.
                  result    <= base_r ^ mask;
                  err       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  // Stops at pos_r, so the mask never shifts past the MSB.
                  mask <= mask << 1;
                  cnt  <= cnt + 1'b1;
               end
            end

            S_DONE: begin
               if (!out_valid) begin
                  // Arrived via the no-scan shortcut: present now.
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule : diff_apply

// File: tb/tb_diff_apply.sv
// Directed self-checking bench for diff_apply, plus a randomised round trip
// against a behavioural lowest-differing-bit finder.
module tb_diff_apply;
   import diff_apply_pkg::*;

   localparam int W  = DIFF_WIDTH;
   localparam int PW = DIFF_POS_W;
   localparam int TIMEOUT = 100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  base = '0;
   logic [PW-1:0] pos = '0;
   logic          no_diff = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          err;

   int n_checks = 0;
   int n_errors = 0;

   diff_apply dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .base      (base),
      .pos       (pos),
      .no_diff   (no_diff),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Behavioural finder: index of the lowest bit where a and b differ.
   function automatic int finder(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] d;
      d = a ^ b;
      for (int i = 0; i < W; i++)
         if (d[i]) return i;
      return 0;
   endfunction

   // Present one request while idle; returns #1 after the accept edge.
   task automatic send(input string tag, input logic [W-1:0] b, input int p, input logic nd);
      check({tag, "_in_ready_before"}, W'(in_ready), W'(1));
      base     = b;
      pos      = PW'(p);
      no_diff  = nd;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      base     = ~b;           // later input changes must not matter
      pos      = ~PW'(p);
      no_diff  = ~nd;
   endtask

   // Counts edges after the accept edge until out_valid is seen; also
   // reports whether in_ready ever went high while waiting.
   task automatic wait_valid(output int n, output logic ready_seen);
      n = 0;
      ready_seen = 1'b0;
      while (!out_valid && n < TIMEOUT) begin
         if (in_ready) ready_seen = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // Output handshake; afterwards the unit must be idle again.
   task automatic take(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_out_valid_cleared"}, W'(out_valid), W'(0));
      check({tag, "_in_ready_after"}, W'(in_ready), W'(1));
   endtask

   initial begin
      int   n;
      logic rdy;
      logic bad_valid, bad_ready, bad_result;
      logic [W-1:0] a, b, exp;
      int   p;

      // ---- 1: reset, including reset in the middle of a scan ----
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_result", result, '0);
      check("rst_err", W'(err), W'(0));
      check("rst_in_ready", W'(in_ready), W'(1));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send("t1", 32'hFFFF_0000, 20, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check("t1_busy", W'(in_ready), W'(0));
      rst_n = 1'b0;
      #1;
      check("t1_rst_out_valid", W'(out_valid), W'(0));
      check("t1_rst_result", result, '0);
      check("t1_rst_in_ready", W'(in_ready), W'(1));
      @(negedge clk);
      rst_n = 1'b1;
      bad_valid = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (out_valid) bad_valid = 1'b1;
      end
      check("t1_no_output_after_reset", W'(bad_valid), W'(0));

      // ---- 2: pos=0, single scan cycle ----
      send("t2", 32'h0000_0000, 0, 1'b0);
      wait_valid(n, rdy);
      check("t2_latency", W'(n), W'(1));
      check("t2_result", result, 32'h0000_0001);
      check("t2_err", W'(err), W'(0));
      take("t2");

      // ---- 3: pos=31, mask reaches the MSB ----
      send("t3", 32'hFFFF_FFFF, 31, 1'b0);
      wait_valid(n, rdy);
      check("t3_latency", W'(n), W'(32));
      check("t3_in_ready_low", W'(rdy), W'(0));
      check("t3_result", result, 32'h7FFF_FFFF);
      check("t3_err", W'(err), W'(0));
      take("t3");

      // ---- 4: no_diff returns base unchanged ----
      send("t4", 32'hDEAD_BEEF, 7, 1'b1);
      wait_valid(n, rdy);
      check("t4_latency", W'(n), W'(1));
      check("t4_result", result, 32'hDEAD_BEEF);
      check("t4_err", W'(err), W'(0));
      take("t4");

      // ---- out_ready while idle has no effect ----
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("idle_out_ready_valid", W'(out_valid), W'(0));
      check("idle_out_ready_in_ready", W'(in_ready), W'(1));

      // ---- 5: backpressure and a held second request ----
      send("t5", 32'h0000_0000, 4, 1'b0);
      wait_valid(n, rdy);
      check("t5_latency", W'(n), W'(5));
      base     = 32'h0000_0001;
      pos      = PW'(1);
      no_diff  = 1'b0;
      in_valid = 1'b1;
      bad_valid = 1'b0;
      bad_ready = 1'b0;
      bad_result = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (!out_valid) bad_valid = 1'b1;
         if (in_ready) bad_ready = 1'b1;
         if (result !== 32'h0000_0010) bad_result = 1'b1;
      end
      check("t5_valid_held", W'(bad_valid), W'(0));
      check("t5_not_ready_while_held", W'(bad_ready), W'(0));
      check("t5_result_held", W'(bad_result), W'(0));
      check("t5_result", result, 32'h0000_0010);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("t5_handshake_valid", W'(out_valid), W'(0));
      check("t5_idle_after_handshake", W'(in_ready), W'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("t5_second_accepted", W'(in_ready), W'(0));
      wait_valid(n, rdy);
      check("t5_second_latency", W'(n), W'(2));
      check("t5_second_result", result, 32'h0000_0003);
      take("t5_second");

      // ---- 6: random round trip against the finder ----
      for (int k = 0; k < 1000; k++) begin
         a = $urandom();
         do b = $urandom(); while (b == a);
         p = finder(a, b);
         exp = a ^ (W'(1) << p);
         send("t6", a, p, 1'b0);
         wait_valid(n, rdy);
         check("t6_latency", W'(n), W'(p + 1));
         check("t6_result", result, exp);
         check("t6_err", W'(err), W'(0));
         check("t6_finder_roundtrip", W'(finder(a, result)), W'(p));
         take("t6");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_diff_apply
